// File: rtl/seven_segment_pkg.sv
// Shared types, constants and the nibble selector for the seven-segment scanner.
package seven_segment_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int MAX_VAL_W  = 4 * MAX_DIGITS;

  typedef logic [6:0] seg_t;

  // Active-low cathode pattern with every segment off.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Selects nibble idx from a zero-extended packed hex value.
  function automatic logic [3:0] nibble_select(input logic [MAX_VAL_W-1:0] val,
                                               input logic [2:0]           idx);
    logic [MAX_VAL_W-1:0] w_shifted;
    w_shifted = val >> {idx, 2'b00};
    return w_shifted[3:0];
  endfunction

endpackage

// File: rtl/seven_segment_scanner_bto7s.sv
// bto7s: hex nibble to active-high seven-segment pattern, s_out = {sg,sf,se,sd,sc,sb,sa}.
module bto7s
  import seven_segment_pkg::*;
(
  input  logic [3:0] x_in,
  output seg_t       s_out
);

  always_comb begin
    s_out = 7'h00;
    case (x_in)
      4'h0: s_out = 7'h3F;
      4'h1: s_out = 7'h06;
      4'h2: s_out = 7'h5B;
      4'h3: s_out = 7'h4F;
      4'h4: s_out = 7'h66;
      4'h5: s_out = 7'h6D;
      4'h6: s_out = 7'h7D;
      4'h7: s_out = 7'h07;
      4'h8: s_out = 7'h7F;
      4'h9: s_out = 7'h6F;
      4'hA: s_out = 7'h77;
      4'hB: s_out = 7'h7C;
      4'hC: s_out = 7'h39;
      4'hD: s_out = 7'h5E;
      4'hE: s_out = 7'h79;
      4'hF: s_out = 7'h71;
      default: s_out = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with registered active-low outputs.
// Optional leading-zero blanking: define SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  output logic [6:0]              cat_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    scan_done_out
);

  localparam int CNT_W = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_PERIOD - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [DIG_W-1:0]        r_digit;
  logic [4*NUM_DIGITS-1:0] r_valQ;

  logic                    w_slotEnd;
  logic                    w_scanEnd;
  logic [MAX_VAL_W-1:0]    w_valExt;
  logic [3:0]              w_nib;
  seg_t                    w_seg;
  logic                    w_blank;
  logic                    w_hide;
  logic [NUM_DIGITS-1:0]   w_anSel;
  logic [NUM_DIGITS-1:0]   w_anNext;

  assign w_slotEnd = (r_cnt == CNT_LAST);
  assign w_scanEnd = w_slotEnd && (r_digit == DIG_LAST);

  assign w_valExt = MAX_VAL_W'(r_valQ);
  assign w_nib    = nibble_select(w_valExt, 3'(r_digit));

  bto7s u_bto7s (
    .x_in  (w_nib),
    .s_out (w_seg)
  );

  // Signed compare keeps BLANK_CYCLES=0 a plain always-false test.
  assign w_blank = (int'(r_cnt) < BLANK_CYCLES);

`ifdef SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
  // w_zeroFrom[i]: nibbles i..NUM_DIGITS-1 of the captured value are all zero.
  logic [NUM_DIGITS-1:0] w_zeroFrom;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign w_zeroFrom[gi] = (r_valQ[4*gi +: 4] == 4'h0);
    end else begin : g_mid
      assign w_zeroFrom[gi] = (r_valQ[4*gi +: 4] == 4'h0) && w_zeroFrom[gi+1];
    end
  end

  always_comb begin
    w_hide = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if ((r_digit == DIG_W'(i)) && w_zeroFrom[i]) begin
        w_hide = 1'b1;
      end
    end
  end
`else
  assign w_hide = 1'b0;
`endif

  assign w_anSel  = NUM_DIGITS'(1) << r_digit;
  assign w_anNext = (w_blank || w_hide) ? '1 : ~w_anSel;

  // Counters, end-of-scan capture and output registers all advance from the pre-edge state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt         <= '0;
      r_digit       <= '0;
      r_valQ        <= '0;
      cat_out       <= SEG_BLANK;
      an_out        <= '1;
      scan_done_out <= 1'b0;
    end else begin
      if (w_slotEnd) begin
        r_cnt   <= '0;
        r_digit <= w_scanEnd ? '0 : r_digit + DIG_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_scanEnd) begin
        r_valQ <= val_in;
      end
      scan_done_out <= w_scanEnd;
      cat_out       <= ~w_seg;
      an_out        <= w_anNext;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a 4-digit scanner (period 4, blank 1) and a 1-digit scanner (period 4, blank 0).
module tb_seven_segment_scanner;

  // Active-low cathode patterns, bit6=g .. bit0=a.
  localparam logic [6:0] CAT_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [6:0] cat0;
    logic [3:0] an0;
    logic       done0;
    logic [6:0] cat1;
    logic       an1;
    logic       done1;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] val_in = 16'h0000;
  logic [3:0]  val1_in = 4'h0;

  logic [6:0]  cat0, cat1;
  logic [3:0]  an0;
  logic        an1;
  logic        done0, done1;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;

  int          k = 0;
  logic [15:0] curVal = 16'h0000;
  logic [3:0]  cur1 = 4'h0;

  always #5 clk_in = ~clk_in;

  seven_segment_scanner #(.NUM_DIGITS(4), .COUNT_PERIOD(4), .BLANK_CYCLES(1)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .val_in        (val_in),
    .cat_out       (cat0),
    .an_out        (an0),
    .scan_done_out (done0)
  );

  seven_segment_scanner #(.NUM_DIGITS(1), .COUNT_PERIOD(4), .BLANK_CYCLES(0)) dut1 (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .val_in        (val1_in),
    .cat_out       (cat1),
    .an_out        (an1),
    .scan_done_out (done1)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, actual, required);
    end
  endtask

  // Drives one cycle of inputs and queues what the outputs must show after the next edge.
  task automatic applyStimulus(input logic rst, input logic [15:0] v, input logic [3:0] v1);
    exp_t        e;
    int          p, cnt, dig;
    logic [15:0] sh;
    @(negedge clk_in);
    rst_in  = rst;
    val_in  = v;
    val1_in = v1;
    if (rst) begin
      e = '{cat0: 7'h7F, an0: 4'hF, done0: 1'b0, cat1: 7'h7F, an1: 1'b1, done1: 1'b0};
      k = 0;
      curVal = 16'h0000;
      cur1 = 4'h0;
    end else begin
      k++;
      p   = k - 1;
      cnt = p % 4;
      dig = (p / 4) % 4;
      sh  = curVal >> (4 * dig);
      e.cat0 = CAT_TAB[sh[3:0]];
      e.an0  = (cnt < 1) ? 4'hF : ~(4'b0001 << dig);
`ifdef SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
      if (dig > 0 && sh == 16'h0000) e.an0 = 4'hF;
`endif
      e.done0 = (k % 16 == 0);
      if (k % 16 == 0) curVal = v;
      e.cat1  = CAT_TAB[cur1];
      e.an1   = 1'b0;
      e.done1 = (k % 4 == 0);
      if (k % 4 == 0) cur1 = v1;
    end
    q.push_back(e);
  endtask

  // Monitor: compares every cycle the stimulus side has queued an expectation for.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("cat0",  8'(cat0),  8'(e.cat0));
        checkOutput("an0",   8'(an0),   8'(e.an0));
        checkOutput("done0", 8'(done0), 8'(e.done0));
        checkOutput("cat1",  8'(cat1),  8'(e.cat1));
        checkOutput("an1",   8'(an1),   8'(e.an1));
        checkOutput("done1", 8'(done1), 8'(e.done1));
      end
    end
  end

  initial begin
    $display("[TB] start");
    repeat (3) applyStimulus(1'b1, 16'h1234, 4'h0);
    for (int i = 1; i <= 23; i++) applyStimulus(1'b0, 16'h1234, 4'(i * 7));
    for (int i = 24; i <= 58; i++) applyStimulus(1'b0, 16'hABCD, 4'(i * 5));
    applyStimulus(1'b1, 16'hABCD, 4'hF);
    for (int i = 1; i <= 36; i++) applyStimulus(1'b0, 16'h0050, 4'(i * 3));
    for (int i = 37; i <= 70; i++) applyStimulus(1'b0, 16'h0000, 4'(i));
    repeat (2) @(negedge clk_in);
    checkOutput("queue_drain", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
